// File: rtl/maf_pkg.sv
// Shared constants and types for the fused multiply-add pipeline sequencer.
// Stage indices follow the datapath order T1 .. T5.
package maf_pkg;

    localparam int STAGES = 6;
    localparam int CONT_W = 3;
    localparam int TAG_W  = 4;

    localparam int ST_T1   = 0;
    localparam int ST_T2   = 1;
    localparam int ST_T3   = 2;
    localparam int ST_T4_1 = 3;
    localparam int ST_T4_2 = STAGES - 2;
    localparam int ST_T5   = STAGES - 1;

    localparam logic [1:0] ESH_XNORM = 2'b11;

    typedef logic [CONT_W-1:0] cont_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef struct packed {
        logic  vld;
        cont_t cont;
        tag_t  tag;
    } slot_t;

    function automatic logic is_xnorm(input logic [1:0] esh);
        return esh == ESH_XNORM;
    endfunction

endpackage

// File: rtl/maf_pipe_ctrl_if.sv
// Issue and result handshakes of the FMA sequencer.
// The slave side is the controller; the master side is issue logic plus result consumer.
interface maf_pipe_ctrl_if
    import maf_pkg::*;
();
    logic  in_valid;
    logic  in_ready;
    cont_t in_cont;
    tag_t  in_tag;
    logic  out_valid;
    logic  out_ready;
    cont_t out_cont;
    tag_t  out_tag;

    modport master (
        output in_valid, in_cont, in_tag, out_ready,
        input  in_ready, out_valid, out_cont, out_tag
    );

    modport slave (
        input  in_valid, in_cont, in_tag, out_ready,
        output in_ready, out_valid, out_cont, out_tag
    );
endinterface

// File: rtl/maf_stage_slot.sv
// Shadow of one datapath stage: valid bit plus the cont/tag travelling with the op.
// Flush only drops the valid bit; cont/tag are don't-care once invalid.
module maf_stage_slot
    import maf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  load,
    input  logic  free,
    input  cont_t cont_in,
    input  tag_t  tag_in,
    output slot_t slot
);

    slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d.vld = 1'b0;
        end else if (load) begin
            slot_d.vld  = 1'b1;
            slot_d.cont = cont_in;
            slot_d.tag  = tag_in;
        end else if (free) begin
            slot_d.vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/maf_pipe_ctrl.sv
// Sequencer for the FMA pipeline: advance chain, load enables, backpressure,
// flush and the extra T5 normalization cycle on a secondary shift.
module maf_pipe_ctrl
    import maf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    maf_pipe_ctrl_if.slave    bus,
    input  logic              flush,
    input  logic [1:0]        esh_t4_2,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_vld,
    output cont_t             cont_t4_2,
    output logic [2:0]        inflight,
    output logic              busy
);

    slot_t             slots [STAGES];
    logic [STAGES-1:0] vld, adv, en;
    logic              gate, hold, out_valid_c, in_ready_c, fire_out, accept;
    logic              xnorm_q, xnorm_d;
    logic [2:0]        inflight_q, inflight_d;

    // Advance chain runs from T5 backwards so a free slot anywhere lets bubbles collapse.
    always_comb begin
        adv         = '0;
        en          = '0;
        gate        = !rst && !flush;
        hold        = vld[ST_T5] && xnorm_q;
        out_valid_c = gate && vld[ST_T5] && !hold;
        fire_out    = out_valid_c && bus.out_ready;
        adv[ST_T5]  = !vld[ST_T5] || fire_out;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = !vld[i] || adv[i+1];
        end
        in_ready_c = gate && adv[0];
        accept     = bus.in_valid && in_ready_c;
        en[0]      = accept;
        for (int i = 1; i < STAGES; i++) begin
            en[i] = gate && vld[i-1] && adv[i];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        cont_t c_in;
        tag_t  t_in;
        if (g == 0) begin : g_head
            assign c_in = bus.in_cont;
            assign t_in = bus.in_tag;
        end else begin : g_body
            assign c_in = slots[g-1].cont;
            assign t_in = slots[g-1].tag;
        end
        maf_stage_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load    (en[g]),
            .free    (adv[g]),
            .cont_in (c_in),
            .tag_in  (t_in),
            .slot    (slots[g])
        );
        assign vld[g] = slots[g].vld;
    end

    // The secondary-shift flag lives for exactly one cycle of T5 occupancy.
    always_comb begin
        xnorm_d    = xnorm_q;
        inflight_d = inflight_q + {2'b00, accept} - {2'b00, fire_out};
        if (flush) begin
            xnorm_d    = 1'b0;
            inflight_d = 3'd0;
        end else if (en[ST_T5]) begin
            xnorm_d = is_xnorm(esh_t4_2);
        end else if (vld[ST_T5]) begin
            xnorm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xnorm_q    <= 1'b0;
            inflight_q <= 3'd0;
        end else begin
            xnorm_q    <= xnorm_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_cont  = slots[ST_T5].cont;
    assign bus.out_tag   = slots[ST_T5].tag;
    assign stage_en      = en;
    assign stage_vld     = vld;
    assign cont_t4_2     = slots[ST_T4_2].cont;
    assign inflight      = inflight_q;
    assign busy          = inflight_q != 3'd0;

endmodule
